// File: rtl/mac_req_arbiter.sv
// mac_req_arbiter
//   Shares one multiply-add pipeline (result = a*b + c) between NUM_REQ requesters.
//   Requests are granted round-robin. Each issued op carries its requester ID down a tag pipe
//   that runs alongside the MAC pipeline. Results are queued in a first-word-fall-through
//   response FIFO, tagged with that ID. The pipeline cannot stall its output, so issue is
//   credit-limited: ops in flight plus queued responses never exceed RSP_DEPTH. This means
//   every result that comes back always has a FIFO slot.
//
// Optional feature: define MAC_REQ_ARB_CHECK_EN to build the sticky protocol checker that
//   drives err. Without it, err is tied to 0.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   MAC_LAT    pipeline latency in cycles (>= 2)
//   RSP_DEPTH  response FIFO entries (>= MAC_LAT, power of 2)
//
// Ports
//   clk, reset_n               clock (rising edge), async active-low reset
//   req_valid/req_ready        per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b/req_c          packed operands; requester i at [8i+:8] / [16i+:16]
//   mac_valid_in/mac_ready_out issue handshake towards the pipeline
//   mac_in_a/b/c               operands of the granted requester
//   mac_valid_out/mac_result   pipeline result (no backpressure)
//   mac_ready_in               constant 1
//   rsp_valid/rsp_ready        response FIFO head handshake
//   rsp_id/rsp_data            head requester ID and result (0 when empty)
//   busy                       op in flight or response queued
//   err                        sticky protocol error
module mac_req_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAC_LAT   = 4,
    parameter int unsigned RSP_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*8-1:0]       req_a,
    input  logic [NUM_REQ*8-1:0]       req_b,
    input  logic [NUM_REQ*16-1:0]      req_c,
    output logic                       mac_valid_in,
    input  logic                       mac_ready_out,
    output logic [7:0]                 mac_in_a,
    output logic [7:0]                 mac_in_b,
    output logic [15:0]                mac_in_c,
    input  logic                       mac_valid_out,
    input  logic [15:0]                mac_result,
    output logic                       mac_ready_in,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [15:0]                rsp_data,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Round-robin pointer: last granted requester.
    logic [ID_W-1:0]  ptr_q;

    // Occupancy accounting for credit.
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W:0]   credit_used;
    logic             credit_ok;

    // Tag pipe mirroring the MAC pipeline.
    logic [MAC_LAT-1:0] tag_v_q;
    logic [ID_W-1:0]    tag_id_q [MAC_LAT];

    // Response FIFO storage.
    logic [ID_W-1:0]  fifo_id_q   [RSP_DEPTH];
    logic [15:0]      fifo_data_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    logic             grant_found;
    logic             grant_any;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic             issue;
    logic             ret;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // Pops and pushes in the current cycle are deliberately not counted.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign credit_ok   = credit_used < (CNT_W + 1)'(RSP_DEPTH);

    // First valid requester after the pointer, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((32'(ptr_q) + off) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_any = grant_found & credit_ok;

    // The pipeline counts raw valid_in, so valid is only raised while it is ready.
    assign mac_valid_in = grant_any & mac_ready_out;
    assign issue        = mac_valid_in;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign mac_in_a     = req_a[32'(grant_idx) * 8 +: 8];
    assign mac_in_b     = req_b[32'(grant_idx) * 8 +: 8];
    assign mac_in_c     = req_c[32'(grant_idx) * 16 +: 16];
    assign mac_ready_in = 1'b1;

    // FIFO control. A push into a full FIFO is only taken when the head leaves the same cycle.
    assign rsp_valid = (fifo_cnt_q != '0);
    assign fifo_full = (fifo_cnt_q == CNT_W'(RSP_DEPTH));
    assign pop       = rsp_valid & rsp_ready;
    assign push      = mac_valid_out & (~fifo_full | pop);
    // A stray result with nothing in flight must not underflow the counter.
    assign ret       = mac_valid_out & (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !ret) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && ret) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= ID_W'(NUM_REQ - 1);
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_v_q    <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            if (issue) begin
                ptr_q <= grant_idx;
            end
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            tag_v_q     <= {tag_v_q[MAC_LAT-2:0], issue};
            tag_id_q[0] <= grant_idx;
            for (int i = 1; i < MAC_LAT; i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q]   <= tag_id_q[MAC_LAT-1];
            fifo_data_q[wr_ptr_q] <= mac_result;
        end
    end

    assign rsp_id   = rsp_valid ? fifo_id_q[rd_ptr_q] : '0;
    assign rsp_data = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign busy     = (inflight_q != '0) | rsp_valid;

`ifdef MAC_REQ_ARB_CHECK_EN
    logic               err_q;
    logic               err_event;
    logic [NUM_REQ-1:0] req_valid_q;
    logic [NUM_REQ-1:0] req_ready_q;

    // A requester that was waiting last cycle must still be valid now.
    assign err_event = (mac_valid_out & ~tag_v_q[MAC_LAT-1])
                     | (tag_v_q[MAC_LAT-1] & ~mac_valid_out)
                     | (mac_valid_out & fifo_full & ~pop)
                     | (|(req_valid_q & ~req_ready_q & ~req_valid));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q       <= 1'b0;
            req_valid_q <= '0;
            req_ready_q <= '0;
        end else begin
            err_q       <= err_q | err_event;
            req_valid_q <= req_valid;
            req_ready_q <= req_ready;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_req_arbiter.sv
// Directed bench for mac_req_arbiter with a behavioural 4-stage MAC pipeline whose input
// ready drops for one cycle after every accept.
module tb_mac_req_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [63:0] req_c;
    logic        mac_valid_in;
    logic        mac_ready_out;
    logic [7:0]  mac_in_a;
    logic [7:0]  mac_in_b;
    logic [15:0] mac_in_c;
    logic        mac_valid_out;
    logic [15:0] mac_result;
    logic        mac_ready_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    mac_req_arbiter #(
        .NUM_REQ   (4),
        .MAC_LAT   (4),
        .RSP_DEPTH (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_c         (req_c),
        .mac_valid_in  (mac_valid_in),
        .mac_ready_out (mac_ready_out),
        .mac_in_a      (mac_in_a),
        .mac_in_b      (mac_in_b),
        .mac_in_c      (mac_in_c),
        .mac_valid_out (mac_valid_out),
        .mac_result    (mac_result),
        .mac_ready_in  (mac_ready_in),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline model, reset from the same source as the arbiter.
    logic [3:0]  pv;
    logic [15:0] pr [4];
    logic        mrdy;
    logic        force_vo;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv   <= '0;
            mrdy <= 1'b1;
            for (int i = 0; i < 4; i++) pr[i] <= '0;
        end else begin
            mrdy  <= !(mac_valid_in && mrdy);
            pv    <= {pv[2:0], mac_valid_in};
            pr[0] <= 16'(16'(mac_in_a) * 16'(mac_in_b)) + mac_in_c;
            for (int i = 1; i < 4; i++) pr[i] <= pr[i-1];
        end
    end

    assign mac_ready_out = mrdy;
    assign mac_valid_out = pv[3] | force_vo;
    assign mac_result    = pr[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] c);
        req_a[8*id +: 8]   = a;
        req_b[8*id +: 8]   = b;
        req_c[16*id +: 16] = c;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Called at a negedge; holds req_valid[id] until n handshakes, drops it right after the last.
    task automatic issue_n(input int id, input int n);
        int cnt;
        int t;
        cnt = 0;
        t   = 0;
        req_valid[id] = 1'b1;
        while (cnt < n && t < 200) begin
            #1;
            if (mac_valid_in && req_ready[id]) cnt++;
            @(negedge clk);
            t++;
        end
        req_valid[id] = 1'b0;
        chk("issue_n_count", cnt, n);
    endtask

    int exp_g [5] = '{0, 1, 2, 3, 0};
    int exp_d [5] = '{30, 133, 236, 339, 30};
    int lat;
    int t;
    int n;
    int got;
    int iss;
    logic drop;

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        rsp_ready = 1'b0;
        force_vo  = 1'b0;
        #2;
        chk("rst_mac_valid_in", mac_valid_in, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("mac_ready_in", mac_ready_in, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single op from requester 0: 3*4+5 = 17, response 5 cycles after the handshake.
        set_ops(0, 8'd3, 8'd4, 16'd5);
        req_valid[0] = 1'b1;
        #1;
        chk("t1_req_ready", req_ready, 4'b0001);
        chk("t1_mac_valid_in", mac_valid_in, 1);
        chk("t1_mac_in_a", mac_in_a, 3);
        chk("t1_mac_in_b", mac_in_b, 4);
        chk("t1_mac_in_c", mac_in_c, 5);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("t1_busy_inflight", busy, 1);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", lat, 5);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_data", rsp_data, 17);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t1_rsp_valid_after_pop", rsp_valid, 0);
        chk("t1_busy_after_pop", busy, 0);

        // Four requesters at once: grants 0,1,2,3,0 on alternating cycles.
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 8'(10 + i), 8'd3, 16'(100 * i));
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t2_mac_valid_in", mac_valid_in, (c % 2 == 0));
            if (c % 2 == 0) chk("t2_grant", req_ready, 1 << exp_g[c/2]);
            @(negedge clk);
            if (c % 2 == 0 && c != 0) req_valid[exp_g[c/2]] = 1'b0;
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            while (!rsp_valid && t < 30) begin
                @(negedge clk);
                t++;
            end
            chk("t2_rsp_valid", rsp_valid, 1);
            chk("t2_rsp_id", rsp_id, exp_g[k]);
            chk("t2_rsp_data", rsp_data, exp_d[k]);
            @(negedge clk);
        end
        rsp_ready = 1'b0;

        // Consumer stalled, requester 1 streams 255*255+0xFFFF: credit caps issue at 8.
        set_ops(1, 8'd255, 8'd255, 16'hFFFF);
        req_valid[1] = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (mac_valid_in && req_ready[1]) n++;
            @(negedge clk);
        end
        chk("t3_issued_until_full", n, 8);
        #1;
        chk("t3_req_ready_blocked", req_ready, 0);
        chk("t3_mac_valid_in_blocked", mac_valid_in, 0);
        chk("t3_busy", busy, 1);
        chk("t3_rsp_id", rsp_id, 1);
        chk("t3_rsp_data_wrap", rsp_data, 16'hFE00);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (mac_valid_in && req_ready[1]) n++;
            @(negedge clk);
        end
        chk("t3_one_more_issue", n, 1);
        rsp_ready = 1'b1;
        got = 1;
        iss = 0;
        for (int c = 0; c < 100 && got < 10; c++) begin
            #1;
            drop = 1'b0;
            if (mac_valid_in && req_ready[1]) begin
                iss++;
                drop = 1'b1;
            end
            if (rsp_valid) begin
                got++;
                chk("t3_drain_id", rsp_id, 1);
                chk("t3_drain_data", rsp_data, 16'hFE00);
            end
            @(negedge clk);
            if (drop) req_valid[1] = 1'b0;
        end
        chk("t3_drain_issue", iss, 1);
        chk("t3_total_results", got, 10);
        rsp_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_idle_rsp_valid", rsp_valid, 0);
        chk("t3_idle_busy", busy, 0);

        // Reset with ops in flight and responses queued.
        set_ops(2, 8'd2, 8'd3, 16'd1);
        issue_n(2, 4);
        #1;
        chk("t4_pre_rsp_valid", rsp_valid, 1);
        chk("t4_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_rsp_valid", rsp_valid, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_rsp_data", rsp_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        set_ops(3, 8'd7, 8'd8, 16'd9);
        issue_n(3, 1);
        t = 0;
        while (!rsp_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("t4_new_rsp_valid", rsp_valid, 1);
        chk("t4_new_rsp_id", rsp_id, 3);
        chk("t4_new_rsp_data", rsp_data, 65);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        repeat (8) @(negedge clk);
        chk("t4_no_stale_rsp", rsp_valid, 0);
        chk("t4_idle_busy", busy, 0);

        chk("err_clean", err, 0);
`ifdef MAC_REQ_ARB_CHECK_EN
        // Result with an empty tag pipe: err rises next cycle and sticks until reset.
        force_vo = 1'b1;
        @(negedge clk);
        force_vo = 1'b0;
        chk("t5_err_set", err, 1);
        repeat (5) @(negedge clk);
        chk("t5_err_sticky", err, 1);
        do_reset();
        chk("t5_err_cleared", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
